// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo / fifo_rd_dwc codebase slice.
package fifo_pkg;

  typedef enum logic {DWC_IDLE, DWC_SHIFT} dwc_state_t;

  // Counter/pointer width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; FWFT_MODE=1 presents the head word on rdata whenever empty=0.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit FWFT_MODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty
);

  localparam int AW = clog2_min1(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wen && !full;
  assign do_rd = ren && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
    if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

  if (FWFT_MODE) begin : g_fwft
    assign rdata = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    always_comb begin
      rdata_d = rdata_q;
      if (do_rd) rdata_d = mem_q[rd_ptr_q];
    end
    always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/fifo_rd_dwc.sv
// Read-side width down-converter behind an FWFT sync_fifo: one word in, RATIO beats out.
// Define FIFO_RD_DWC_MSB_FIRST_EN for MSB-first beat order (default LSB-first).
module fifo_rd_dwc
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CW    = clog2_min1(RATIO);
  localparam logic [CW-1:0] PENULT_CNT = CW'(RATIO - 2);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || (DATA_WIDTH / OUT_WIDTH) < 2) begin : g_bad_cfg
    $error("fifo_rd_dwc: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
  end

  dwc_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  out_last_q, out_last_d;
  logic                  xfer;

  // valid/ready: a beat moves on out_valid && out_ready; while out_valid is
  // high without ready, data and last hold and valid stays up (only rst drops it).
  assign out_valid = (state_q == DWC_SHIFT);
  assign busy      = (state_q == DWC_SHIFT);
  assign out_last  = out_last_q;
  assign xfer      = out_valid && out_ready;

  // Refill straight from the last beat's transfer keeps words back-to-back.
  assign fifo_ren = !rst && !fifo_empty && ((state_q == DWC_IDLE) || (xfer && out_last_q));

`ifdef FIFO_RD_DWC_MSB_FIRST_EN
  assign out_data = shreg_q[DATA_WIDTH-1 -: OUT_WIDTH];
`else
  assign out_data = shreg_q[OUT_WIDTH-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    out_last_d = out_last_q;
    if (fifo_ren) begin
      state_d    = DWC_SHIFT;
      shreg_d    = fifo_rdata;
      beat_cnt_d = '0;
      out_last_d = 1'b0;
    end else if (xfer) begin
      if (out_last_q) begin
        state_d    = DWC_IDLE;
        out_last_d = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + CW'(1);
        out_last_d = (beat_cnt_q == PENULT_CNT);
`ifdef FIFO_RD_DWC_MSB_FIRST_EN
        shreg_d    = shreg_q << OUT_WIDTH;
`else
        shreg_d    = shreg_q >> OUT_WIDTH;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DWC_IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_dwc.sv
// Bench for fifo_rd_dwc behind a 4-deep FWFT sync_fifo: cycle tables plus hand sequences.
module tb_fifo_rd_dwc;

  logic        clk = 1'b0;
  logic        rst_fifo, rst_dwc;
  logic        wen;
  logic [15:0] wdata;
  logic        fifo_full, fifo_empty, fifo_ren;
  logic [15:0] fifo_rdata;
  logic        out_valid, out_last, out_ready, busy;
  logic [3:0]  out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .FWFT_MODE(1'b1)) u_fifo (
    .clk(clk), .rst(rst_fifo), .wen(wen), .wdata(wdata), .full(fifo_full),
    .ren(fifo_ren), .rdata(fifo_rdata), .empty(fifo_empty)
  );

  fifo_rd_dwc #(.DATA_WIDTH(16), .OUT_WIDTH(4)) dut (
    .clk(clk), .rst(rst_dwc), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic        wen;
    logic [15:0] wdata;
    logic        rdy;
    logic        rst;
    logic        e_ren;
    logic        e_valid;
    logic        chk_data;
    logic [3:0]  e_data;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];

  function automatic logic [3:0] bt(input logic [15:0] w, input int k);
`ifdef FIFO_RD_DWC_MSB_FIRST_EN
    return w[15-4*k -: 4];
`else
    return w[4*k +: 4];
`endif
  endfunction

  function automatic vec_t mk(input logic w, input logic [15:0] wd, input logic rdy,
                              input logic r, input logic e_ren, input logic e_valid,
                              input logic chk, input logic [3:0] e_data,
                              input logic e_last, input logic e_busy);
    vec_t v;
    v.wen = w; v.wdata = wd; v.rdy = rdy; v.rst = r;
    v.e_ren = e_ren; v.e_valid = e_valid; v.chk_data = chk;
    v.e_data = e_data; v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  // Word in FIFO, popped, then RATIO beats with out_ready held high.
  function automatic void push_free_word(input logic [15:0] w);
    vecs.push_back(mk(1, w, 1, 0, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(w, k), k == 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] wd, input logic rdy, input logic r);
    wen = w; wdata = wd; out_ready = rdy; rst_dwc = r;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.wen, v.wdata, v.rdy, v.rst);
    @(negedge clk);
    chk($sformatf("vec%0d ren", idx), {31'd0, fifo_ren}, {31'd0, v.e_ren});
    chk($sformatf("vec%0d valid", idx), {31'd0, out_valid}, {31'd0, v.e_valid});
    chk($sformatf("vec%0d last", idx), {31'd0, out_last}, {31'd0, v.e_last});
    chk($sformatf("vec%0d busy", idx), {31'd0, busy}, {31'd0, v.e_busy});
    if (v.chk_data)
      chk($sformatf("vec%0d data", idx), {28'd0, out_data}, {28'd0, v.e_data});
    next_cycle();
  endtask

  initial begin
    logic [15:0] words[4];
    int beats, rens, first_v, last_v;

    drive(0, 16'h0, 1, 1);
    rst_fifo = 1'b1;
    repeat (3) next_cycle();
    rst_fifo = 1'b0;

    // Reset state, then single word free flow.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4'h0, 0, 0));
    push_free_word(16'h1234);

    // Backpressure on 16'hABCD: ready 1,0,0,1,1,0,1 from the first valid beat.
    vecs.push_back(mk(1, 16'hABCD, 1, 0, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'hABCD, 0), 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, bt(16'hABCD, 1), 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, bt(16'hABCD, 1), 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'hABCD, 1), 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'hABCD, 2), 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, bt(16'hABCD, 3), 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'hABCD, 3), 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));

    // Reset mid-word: two beats of 5678 go, then rst; 9ABC follows in full.
    vecs.push_back(mk(1, 16'h5678, 1, 0, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 16'h9ABC, 1, 0, 1, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'h5678, 0), 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'h5678, 1), 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, bt(16'h5678, 2), 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 4'h0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'h9ABC, k), k == 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));

    // Refill race: F0F0 written in the cycle the last beat of 0F0F leaves an empty FIFO.
    vecs.push_back(mk(1, 16'h0F0F, 1, 0, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'h0F0F, k), 0, 1));
    vecs.push_back(mk(1, 16'hF0F0, 1, 0, 0, 1, 1, bt(16'h0F0F, 3), 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, bt(16'hF0F0, k), k == 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Back-to-back words: 16 beats with no bubble, one pop per word.
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) exp_q.push_back(bt(words[w], k));
    beats = 0; rens = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 40; c++) begin
      if (c < 4) drive(1, words[c], 1, 0);
      else       drive(0, 16'h0, 1, 0);
      @(negedge clk);
      if (fifo_ren) begin
        rens++;
        if (busy) chk("b2b ren_on_last", {31'd0, out_last}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        beats++;
        if (exp_q.size() == 0) chk("b2b extra_beat", 32'd1, 32'd0);
        else chk($sformatf("b2b beat%0d", beats), {28'd0, out_data}, {28'd0, exp_q.pop_front()});
      end
      next_cycle();
    end
    chk("b2b beats", beats, 32'd16);
    chk("b2b span", last_v - first_v + 1, 32'd16);
    chk("b2b ren_pulses", rens, 32'd4);
    chk("b2b queue_left", exp_q.size(), 32'd0);
    chk("b2b fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // Empty idle: nothing to pop, nothing to send.
    for (int c = 0; c < 20; c++) begin
      drive(0, 16'h0, 1, 0);
      @(negedge clk);
      chk($sformatf("idle%0d ren", c), {31'd0, fifo_ren}, 32'd0);
      chk($sformatf("idle%0d valid", c), {31'd0, out_valid}, 32'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_dwc.md
Name: fifo_rd_dwc

Overview:
- Read-side width down-converter sitting directly downstream of sync_fifo, configured with FWFT_MODE=1.
- Pops one DATA_WIDTH word whenever the FIFO is non-empty and emits it as RATIO narrower beats on a valid/ready stream, flagging the final beat.
- Gives the FIFO a narrow streaming consumer (serial link, byte-wide peripheral) with zero-bubble word-to-word throughput.

Parameters:
- DATA_WIDTH, 16, FIFO word width; must equal the upstream sync_fifo DATA_WIDTH.
- OUT_WIDTH, 4, output beat width; DATA_WIDTH % OUT_WIDTH == 0 and DATA_WIDTH/OUT_WIDTH >= 2, otherwise elaboration error.
- RATIO (localparam), DATA_WIDTH/OUT_WIDTH, beats per word.

Ports:
- clk  input  1  clock; one clock domain, shared with sync_fifo.
- rst  input  1  reset; synchronous, active-high.
- fifo_empty  input  1  sync_fifo empty flag.
- fifo_rdata  input  DATA_WIDTH  sync_fifo read data; FWFT, valid whenever fifo_empty=0.
- fifo_ren  output  1  sync_fifo read enable; one pulse per word.
- out_valid  output  1  beat valid.
- out_data  output  OUT_WIDTH  beat data.
- out_last  output  1  final beat of the current word.
- out_ready  input  1  downstream accept.
- busy  output  1  high while a word is held (state SHIFT).

Behaviour:
- FSM has two states.
  - IDLE: no word held.
  - SHIFT: a word held in shreg[DATA_WIDTH-1:0]; beat_cnt of width clog2(RATIO).
- fifo_ren is combinational: !rst && !fifo_empty && (state==IDLE || (out_valid && out_ready && out_last)). It is never asserted while fifo_empty=1.
- On fifo_ren: shreg <= fifo_rdata, beat_cnt <= 0, state <= SHIFT, in the same edge.
- Latency: fifo_empty falls before edge N, so fifo_ren is high in the cycle before N, and out_valid=1 with beat 0 is visible after edge N (1 cycle).
- In SHIFT: out_valid=1, out_data = current beat slice, out_last = (beat_cnt==RATIO-1). All three are driven from registers / registered state only; no combinational path from out_ready to out_data.
- Handshake: a beat transfers on out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on rst.
- On transfer with !out_last: beat_cnt++, advance to next slice.
- On transfer with out_last:
  - If !fifo_empty: pop the next word in the same cycle; stay SHIFT with beat_cnt=0 (no bubble, sustained 1 beat/cycle).
  - Else: state <= IDLE, out_valid <= 0.
- Beat order (macro absent): LSB-first. Beat k = word[k*OUT_WIDTH +: OUT_WIDTH].
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, beat_cnt=0, shreg=0. fifo_ren=0 while rst=1.
- Reset mid-word: the partially sent word is discarded; the FIFO is not re-read for it.
- The upstream FIFO may be written during any state; this block only reads.
- fifo_empty rising while in SHIFT has no effect until the last beat transfers.

Optional Feature:
- Macro: FIFO_RD_DWC_MSB_FIRST_EN.
- Defined: beats go MSB-first. Beat k = word[DATA_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH].
- Undefined: LSB-first as above.
- Timing, handshake and out_last position are identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - typedef enum logic {DWC_IDLE, DWC_SHIFT} dwc_state_t;
  - function clog2_min1(n), returning at least 1 for counter width.
- No sub-module. The FSM, beat counter and slice mux fit in one module (about 150 lines).
- The testbench instantiates sync_fifo (FIFO_DEPTH=4, DATA_WIDTH=16, FWFT_MODE=1) upstream, with this block wired to its ren/rdata/empty.

Test Plan:
1. Single word, free flow: write 16'h1234, out_ready=1 held.
   - Macro off: beats 4,3,2,1 on 4 consecutive cycles, out_last on the 4th, one fifo_ren pulse, then out_valid=0 and busy=0.
   - Macro on: beats 1,2,3,4.
2. Back-to-back: write 16'h1111, 16'h2222, 16'h3333, 16'h4444 (FIFO full), out_ready=1.
   - 16 consecutive valid beats, no bubble.
   - fifo_ren pulses coincide with each out_last transfer.
   - FIFO ends empty.
3. Backpressure: write 16'hABCD, out_ready toggles 1,0,0,1,1,0,1.
   - out_data holds during the ready=0 cycles.
   - Beats D,C,B,A are each delivered exactly once; out_last only with A.
4. Empty idle: 20 cycles with no writes and out_ready=1 → fifo_ren=0, out_valid=0 throughout.
5. Reset mid-word: write 16'h5678 and 16'h9ABC; assert rst after 2 beats (8,7) have transferred.
   - Next cycle out_valid=0.
   - After release: beats C,B,A,9 from the second word; 6,5 are never emitted.
6. Refill race: FIFO goes empty during the last beat of 16'h0F0F, and 16'hF0F0 is written that same cycle.
   - One-cycle out_valid=0 gap, then F0F0 beats; no duplicated or lost word.
